// File: rtl/canny_window_fetch_if.sv
// Handshake and SRAM-side bundle for canny_window_fetch.
// A window is transferred on every cycle with rd_en=1, which only happens while dn_ready=1; the sink must then take the data RD_LAT cycles later (win_valid) with no further ready check.
interface canny_window_fetch_if #(
    parameter int WIN     = 3,
    parameter int ADDR_W  = 19,
    parameter int WADDR_W = 18
) ();
    logic                      start;
    logic                      dn_ready;
    logic                      busy;
    logic                      done;
    logic                      error;
    logic                      rd_en;
    logic [WIN*WIN*ADDR_W-1:0] rd_addr;
    logic                      win_valid;
    logic                      win_border;
    logic [WADDR_W-1:0]        wr_addr;
    logic                      wr_en;
    logic [1:0]                dbg_state;

    modport master (
        output start, dn_ready,
        input  busy, done, error, rd_en, rd_addr, win_valid, win_border, wr_addr, wr_en, dbg_state
    );

    modport slave (
        input  start, dn_ready,
        output busy, done, error, rd_en, rd_addr, win_valid, win_border, wr_addr, wr_en, dbg_state
    );
endinterface

// File: rtl/canny_window_fetch.sv
// Window address sequencer: walks centre pixels, issues WIN*WIN read addresses, tracks read latency.
// Optional macro CANNY_WINDOW_BORDER_EN: visit every pixel, clamp out-of-image slots, flag border centres.
module canny_window_fetch #(
    parameter int IMG_W     = 520,
    parameter int IMG_H     = 520,
    parameter int WIN       = 3,
    parameter int ADDR_W    = 19,
    parameter int WADDR_W   = 18,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 1
) (
    input logic                  clk,
    input logic                  rst,
    canny_window_fetch_if.slave  bus
);
    localparam int H = WIN / 2;
`ifdef CANNY_WINDOW_BORDER_EN
    localparam int ROW_FIRST = 0;
    localparam int ROW_LAST  = IMG_H - 1;
    localparam int COL_FIRST = 0;
    localparam int COL_LAST  = IMG_W - 1;
    localparam bit DEGEN     = 1'b0;
    localparam logic [31:0] K_IMG_W_M1  = 32'(IMG_W - 1);
    localparam logic [31:0] K_IMG_H_M1  = 32'(IMG_H - 1);
    localparam logic [31:0] K_LAST_BASE = 32'((IMG_H - 1) * IMG_W);
`else
    localparam int ROW_FIRST = H;
    localparam int ROW_LAST  = IMG_H - 1 - H;
    localparam int COL_FIRST = H;
    localparam int COL_LAST  = IMG_W - 1 - H;
    localparam bit DEGEN     = (IMG_W < WIN) || (IMG_H < WIN);
`endif
    localparam logic [31:0] K_H          = 32'(H);
    localparam logic [31:0] K_IMG_W      = 32'(IMG_W);
    localparam logic [31:0] K_ROW_FIRST  = 32'(ROW_FIRST);
    localparam logic [31:0] K_ROW_LAST   = 32'(ROW_LAST);
    localparam logic [31:0] K_COL_FIRST  = 32'(COL_FIRST);
    localparam logic [31:0] K_COL_LAST   = 32'(COL_LAST);
    localparam logic [31:0] K_FIRST_BASE = 32'(ROW_FIRST * IMG_W);
    localparam logic [2:0]  K_DRAIN_LAST = 3'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_row;
    logic [31:0]               r_col;
    logic [31:0]               r_row_base;
    logic [2:0]                r_drain;
    logic                      w_accept;
    logic                      w_issue;
    logic                      w_last;
    logic                      w_border;
    logic [WIN*WIN*ADDR_W-1:0] w_addr_flat;

    logic                      r_pv [RD_LAT];
    logic                      r_pb [RD_LAT];
    logic [WADDR_W-1:0]        r_pa [RD_LAT];

    // A start in DONE is accepted as well, so back-to-back frames lose no cycle.
    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_issue  = (r_state == S_FETCH) && bus.dn_ready;
    assign w_last   = w_issue && (r_row == K_ROW_LAST) && (r_col == K_COL_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = DEGEN ? S_DRAIN : S_FETCH;
            S_FETCH: if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == K_DRAIN_LAST) w_next = S_DONE;
            S_DONE:  w_next = bus.start ? (DEGEN ? S_DRAIN : S_FETCH) : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
        bus.done      = (r_state == S_DONE);
        bus.error     = bus.start && bus.busy;
        bus.rd_en     = w_issue;
        bus.rd_addr   = w_issue ? w_addr_flat : '0;
        bus.dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row      <= '0;
            r_col      <= '0;
            r_row_base <= '0;
        end else if (w_accept) begin
            r_row      <= K_ROW_FIRST;
            r_col      <= K_COL_FIRST;
            r_row_base <= K_FIRST_BASE;
        end else if (w_issue) begin
            if (r_col == K_COL_LAST) begin
                r_col      <= K_COL_FIRST;
                r_row      <= r_row + 32'd1;
                r_row_base <= r_row_base + K_IMG_W;
            end else begin
                r_col <= r_col + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || r_state != S_DRAIN) r_drain <= '0;
        else                           r_drain <= r_drain + 3'd1;
    end

`ifdef CANNY_WINDOW_BORDER_EN
    assign w_border = (r_row < K_H) || (r_row + K_H > K_IMG_H_M1) ||
                      (r_col < K_H) || (r_col + K_H > K_IMG_W_M1);
`else
    assign w_border = 1'b0;
`endif

    // Row offsets are elaborated constants; only the row base and column vary at run time.
    for (genvar gr = 0; gr < WIN; gr++) begin : g_row
        logic [31:0] w_rbase;
`ifdef CANNY_WINDOW_BORDER_EN
        always_comb begin
            if (r_row + 32'(gr) < K_H)                   w_rbase = '0;
            else if (r_row + 32'(gr) > K_IMG_H_M1 + K_H) w_rbase = K_LAST_BASE;
            else w_rbase = r_row_base + 32'(gr * IMG_W) - 32'(H * IMG_W);
        end
`else
        assign w_rbase = r_row_base + 32'(gr * IMG_W) - 32'(H * IMG_W);
`endif
        for (genvar gc = 0; gc < WIN; gc++) begin : g_col
            logic [31:0] w_cidx;
`ifdef CANNY_WINDOW_BORDER_EN
            always_comb begin
                if (r_col + 32'(gc) < K_H)                   w_cidx = '0;
                else if (r_col + 32'(gc) > K_IMG_W_M1 + K_H) w_cidx = K_IMG_W_M1;
                else w_cidx = r_col + 32'(gc) - K_H;
            end
`else
            assign w_cidx = r_col + 32'(gc) - K_H;
`endif
            assign w_addr_flat[(gr*WIN+gc)*ADDR_W +: ADDR_W] =
                ADDR_W'(32'(BASE_ADDR) + w_rbase + w_cidx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pb[i] <= 1'b0;
                r_pa[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pb[0] <= w_issue && w_border;
            r_pa[0] <= w_issue ? WADDR_W'(r_row_base + r_col) : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pb[i] <= r_pb[i-1];
                r_pa[i] <= r_pa[i-1];
            end
        end
    end

    assign bus.win_valid  = r_pv[RD_LAT-1];
    assign bus.win_border = r_pb[RD_LAT-1];
    assign bus.wr_addr    = r_pa[RD_LAT-1];
    assign bus.wr_en      = r_pv[RD_LAT-1];
endmodule

// File: doc/canny_window_fetch.md
Name: canny_window_fetch

Overview:
- Parametrised read/write address sequencer for the Canny pipeline stages.
- Walks every centre pixel of an IMG_W x IMG_H image and issues WIN*WIN neighbourhood read addresses per cycle to the read SRAM bank.
- Tracks SRAM read latency, presents the returned window to the filter stage, and supplies the matching write address to the write SRAM.
- Generalises the fixed 3x3 a..i addressing to any odd WIN, any image size, and any read latency.

Parameters:
- IMG_W, 520, image width in pixels
- IMG_H, 520, image height in pixels
- WIN, 3, window edge length; odd, 3..7
- ADDR_W, 19, read SRAM address width
- WADDR_W, 18, write SRAM address width
- BASE_ADDR, 0, read address of pixel (0,0)
- RD_LAT, 1, read SRAM latency in cycles, 1..4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin one frame pass
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last window leaves the pipeline
- error  out  1  one-cycle pulse when start is asserted while busy
- dn_ready  in  1  downstream can accept a window issued this cycle
- rd_en  out  1  read strobe to all read SRAMs
- rd_addr  out  WIN*WIN*ADDR_W  flattened addresses; slot k = dr*WIN+dc, row-major from top-left
- win_valid  out  1  window data on SRAM outputs is valid this cycle
- win_border  out  1  current centre is a border pixel
- wr_addr  out  WADDR_W  write address of the current centre, r*IMG_W+c
- wr_en  out  1  write strobe to the write SRAM

Behaviour:
- Reset: all outputs 0; state IDLE; row/col counters and latency pipe cleared.
- Reset mid-frame: abandons the frame; nothing further is issued.
- State IDLE: start=1 moves to FETCH; busy rises the next cycle.
- State FETCH: one centre is issued per cycle when dn_ready=1.
  - Issuing drives rd_en=1 and the addresses, and advances col, then row.
  - dn_ready=0: rd_en=0 and the counters hold.
  - After the last centre is issued, go to DRAIN.
- State DRAIN: wait RD_LAT cycles, then go to DONE.
- State DONE: done=1 for one cycle, busy=0, return to IDLE.
- Scan order: row-major. Centre range:
  - H = WIN/2.
  - Rows H..IMG_H-1-H, cols H..IMG_W-1-H (interior only, unless the optional feature is enabled).
- Address arithmetic: no multipliers.
  - A row-base register accumulates IMG_W per row.
  - Slot (dr,dc) = BASE_ADDR + row_base + (dr-H)*IMG_W + col + dc - H.
  - Row offsets (dr-H)*IMG_W are elaborated as constants.
  - Truncate to ADDR_W.
- Latency pipe: RD_LAT-deep shift register of {valid, border, centre index}.
  - Advances every cycle.
  - win_valid, win_border and wr_addr come from its tail.
  - wr_en = win_valid.
  - Downstream must accept every window it allowed; dn_ready is not resampled at the tail.
- Start while busy: ignored; error pulses for one cycle; the frame continues.
- Degenerate size (IMG_W<WIN or IMG_H<WIN): the frame issues nothing; done pulses RD_LAT+1 cycles after start.
- Simultaneous start and done cycle: start is accepted; the next frame begins.

Optional Feature:
- Macro: CANNY_WINDOW_BORDER_EN.
- Defined: every pixel 0..IMG_W*IMG_H-1 is a centre.
  - Centres whose window leaves the image get win_border=1.
  - rd_addr slots are clamped to the nearest in-image pixel (replicate).
  - wr_en still asserts, so the write controller writes 0 there.
- Undefined: only interior centres are issued; win_border is tied to 0.

Test Plan:
- Small frame, feature off (IMG_W=5, IMG_H=4, WIN=3, RD_LAT=2, dn_ready=1, start at cycle 0):
  - 6 issues on cycles 1..6.
  - First rd_addr = 0,1,2,5,6,7,10,11,12.
  - win_valid on cycles 3..8 with wr_addr 6,7,8,11,12,13.
  - done pulses on cycle 9.
- Backpressure: same setup with dn_ready=0 on cycles 2..4.
  - rd_en low on those cycles; counters hold.
  - The sequence resumes at centre 7; done is delayed by 3 cycles.
  - All 6 windows are delivered once, in order.
- Start while busy: start pulse on cycle 3.
  - error=1 for one cycle.
  - Frame output identical to the first test.
- Reset mid-frame: rst on cycle 4.
  - Next cycle all outputs are 0 and no further win_valid.
  - A new start gives a full 6-window frame.
- Feature on (IMG_W=5, IMG_H=4, WIN=3):
  - 20 windows.
  - Centre (0,0) has win_border=1 and rd_addr = 0,0,1,0,0,1,5,5,6.
  - Exactly 6 windows have win_border=0.
- Wide window (WIN=5, 8x8, RD_LAT=1):
  - First rd_addr slot 0 = 0, slot 24 = 36.
  - 16 windows; last wr_addr = 45.
